// File: rtl/bus_transfer_ctrl_pkg.sv
// Shared definitions for the register-bus transfer controller and its arbiter.
package bus_pkg;

    localparam int IDX_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        TURN = 2'd2
    } state_t;

endpackage

// File: rtl/bus_transfer_ctrl_rr_arbiter.sv
// Round-robin arbiter: the first active request at or after ptr (wrapping) wins.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   grant_idx,
    output logic            any
);

    always_comb begin
        int j;
        j         = 0;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!any && req[j]) begin
                any       = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = PW'(j);
            end
        end
    end

endmodule

// File: rtl/bus_transfer_ctrl.sv
// Shared register-bus transfer controller: arbitrates requesters and drives one-hot
// read/write enables. Define BUS_TURNAROUND_EN to insert an idle TURN cycle after each XFER.
module bus_transfer_ctrl
    import bus_pkg::*;
#(
    parameter int N    = 16,
    parameter int NREG = 16,
    parameter int NREQ = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*IDX_W-1:0] req_src,
    input  logic [NREQ*IDX_W-1:0] req_dst,
    output logic [NREQ-1:0]       req_ack,
    output logic                  req_err,
    output logic [NREG-1:0]       rd_en,
    output logic [NREG-1:0]       wr_en,
    output logic                  busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (N < 1 || NREG < 1 || NREG > (1 << IDX_W) || NREQ < 1) begin : g_bad_cfg
        $error("bus_transfer_ctrl: unsupported parameter set");
    end

    state_t            state;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     ptr_next;
    logic [NREQ-1:0]   grant;
    logic [PW-1:0]     grant_idx;
    logic              grant_any;
    logic              can_arb;
    logic [IDX_W-1:0]  win_src;
    logic [IDX_W-1:0]  win_dst;
    logic              win_err;
    logic [NREG-1:0]   rd_next;
    logic [NREG-1:0]   wr_next;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

`ifdef BUS_TURNAROUND_EN
    assign can_arb = (state == IDLE) || (state == TURN);
`else
    assign can_arb = (state != TURN);
`endif

    assign ptr_next = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + PW'(1);

    // Self-copies and out-of-range indices still ack, but must never touch the bus.
    always_comb begin
        win_src = req_src[int'(grant_idx)*IDX_W +: IDX_W];
        win_dst = req_dst[int'(grant_idx)*IDX_W +: IDX_W];
        win_err = (int'(win_src) >= NREG) || (int'(win_dst) >= NREG);
        rd_next = '0;
        wr_next = '0;
        if (!win_err && (win_src != win_dst)) begin
            for (int r = 0; r < NREG; r++) begin
                rd_next[r] = (win_src == IDX_W'(r));
                wr_next[r] = (win_dst == IDX_W'(r));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            req_ack <= '0;
            req_err <= 1'b0;
            rd_en   <= '0;
            wr_en   <= '0;
            busy    <= 1'b0;
        end else begin
            req_ack <= '0;
            req_err <= 1'b0;
            rd_en   <= '0;
            wr_en   <= '0;
            if (can_arb && grant_any) begin
                state   <= XFER;
                ptr     <= ptr_next;
                req_ack <= grant;
                req_err <= win_err;
                rd_en   <= rd_next;
                wr_en   <= wr_next;
                busy    <= 1'b1;
            end else if (can_arb) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                state <= TURN;
                busy  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bus_transfer_ctrl.sv
// Self-checking bench for bus_transfer_ctrl: vector table, corner sequences and random traffic
// against a transaction-level model. Adapts to builds with or without BUS_TURNAROUND_EN.
module tb_bus_transfer_ctrl;

    localparam int N    = 16;
    localparam int NREG = 8;
    localparam int NREQ = 4;
`ifdef BUS_TURNAROUND_EN
    localparam bit TURNAROUND = 1'b1;
`else
    localparam bit TURNAROUND = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [NREQ-1:0]  req_valid;
    logic [NREQ*4-1:0] req_src;
    logic [NREQ*4-1:0] req_dst;
    logic [NREQ-1:0]  req_ack;
    logic             req_err;
    logic [NREG-1:0]  rd_en;
    logic [NREG-1:0]  wr_en;
    logic             busy;

    int vec_count  = 0;
    int miscompares = 0;

    // Model state: round-robin pointer and whether the previous cycle carried a transfer.
    int              m_ptr  = 0;
    bit              m_last = 1'b0;
    logic [NREQ-1:0] e_ack;
    logic            e_err;
    logic [NREG-1:0] e_rd;
    logic [NREG-1:0] e_wr;
    logic            e_busy;

    typedef struct {
        logic            rst;
        logic [3:0]      valid;
        logic [3:0]      src;
        logic [3:0]      dst;
        logic [3:0]      ack;
        logic            err;
        logic [7:0]      rd;
        logic [7:0]      wr;
        logic            busy;
    } vec_t;

    bus_transfer_ctrl #(
        .N    (N),
        .NREG (NREG),
        .NREQ (NREQ)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_src   (req_src),
        .req_dst   (req_dst),
        .req_ack   (req_ack),
        .req_err   (req_err),
        .rd_en     (rd_en),
        .wr_en     (wr_en),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic modelStep();
        int w;
        bit found;
        int s;
        int d;
        w = 0;
        found = 1'b0;
        e_ack = '0;
        e_err = 1'b0;
        e_rd  = '0;
        e_wr  = '0;
        if (rst) begin
            e_busy = 1'b0;
            m_ptr  = 0;
            m_last = 1'b0;
        end else if (!(TURNAROUND && m_last) && (req_valid != 0)) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!found && req_valid[(m_ptr + k) % NREQ]) begin
                    found = 1'b1;
                    w = (m_ptr + k) % NREQ;
                end
            end
            s = int'(req_src[w*4 +: 4]);
            d = int'(req_dst[w*4 +: 4]);
            e_ack[w] = 1'b1;
            e_err = (s >= NREG) || (d >= NREG);
            if (!e_err && s != d) begin
                e_rd[s] = 1'b1;
                e_wr[d] = 1'b1;
            end
            e_busy = 1'b1;
            m_last = 1'b1;
            m_ptr  = (w + 1) % NREQ;
        end else begin
            e_busy = TURNAROUND && m_last;
            m_last = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [3:0] v,
                                 input logic [15:0] s, input logic [15:0] d);
        rst       = r;
        req_valid = v;
        req_src   = s;
        req_dst   = d;
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] ack, input logic err,
                               input logic [7:0] rd, input logic [7:0] wr, input logic b);
        vec_count++;
        if (req_ack !== ack || req_err !== err || rd_en !== rd || wr_en !== wr || busy !== b) begin
            miscompares++;
            $display("[TB] FAIL %s: got ack=%b err=%b rd=%h wr=%h busy=%b, expected ack=%b err=%b rd=%h wr=%h busy=%b",
                     name, req_ack, req_err, rd_en, wr_en, busy, ack, err, rd, wr, b);
        end
    endtask

    task automatic checkValue(input string name, input int got, input int exp);
        vec_count++;
        if (got != exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    initial begin
        vec_t tbl[14];
        int   ack_idx[$];
        int   ack_cyc[$];
        int   order[5];
        logic [15:0] rs;
        logic [15:0] rdst;

        tbl[0]  = '{1'b1, 4'b0000, 4'd0,  4'd0, 4'b0000, 1'b0, 8'h00, 8'h00, 1'b0};
        tbl[1]  = '{1'b0, 4'b0001, 4'd3,  4'd7, 4'b0001, 1'b0, 8'h08, 8'h80, 1'b1};
        tbl[2]  = '{1'b0, 4'b0000, 4'd0,  4'd0, 4'b0000, 1'b0, 8'h00, 8'h00, TURNAROUND};
        tbl[3]  = '{1'b0, 4'b0000, 4'd0,  4'd0, 4'b0000, 1'b0, 8'h00, 8'h00, 1'b0};
        tbl[4]  = '{1'b0, 4'b0010, 4'd5,  4'd5, 4'b0010, 1'b0, 8'h00, 8'h00, 1'b1};
        tbl[5]  = '{1'b0, 4'b0000, 4'd0,  4'd0, 4'b0000, 1'b0, 8'h00, 8'h00, TURNAROUND};
        tbl[6]  = '{1'b0, 4'b0000, 4'd0,  4'd0, 4'b0000, 1'b0, 8'h00, 8'h00, 1'b0};
        tbl[7]  = '{1'b0, 4'b0100, 4'd2,  4'd9, 4'b0100, 1'b1, 8'h00, 8'h00, 1'b1};
        tbl[8]  = '{1'b0, 4'b0000, 4'd0,  4'd0, 4'b0000, 1'b0, 8'h00, 8'h00, TURNAROUND};
        tbl[9]  = '{1'b0, 4'b0000, 4'd0,  4'd0, 4'b0000, 1'b0, 8'h00, 8'h00, 1'b0};
        tbl[10] = '{1'b0, 4'b1000, 4'd12, 4'd1, 4'b1000, 1'b1, 8'h00, 8'h00, 1'b1};
        tbl[11] = '{1'b0, 4'b0000, 4'd0,  4'd0, 4'b0000, 1'b0, 8'h00, 8'h00, TURNAROUND};
        tbl[12] = '{1'b0, 4'b0001, 4'd0,  4'd6, 4'b0001, 1'b0, 8'h01, 8'h40, 1'b1};
        tbl[13] = '{1'b0, 4'b0000, 4'd0,  4'd0, 4'b0000, 1'b0, 8'h00, 8'h00, TURNAROUND};

        $display("[TB] start, turnaround=%0d", TURNAROUND);

        for (int i = 0; i < 14; i++) begin
            applyStimulus(tbl[i].rst, tbl[i].valid, {4{tbl[i].src}}, {4{tbl[i].dst}});
            checkOutput($sformatf("table[%0d]", i), tbl[i].ack, tbl[i].err,
                        tbl[i].rd, tbl[i].wr, tbl[i].busy);
        end

        // All four requesters held high: round-robin order and spacing between acks.
        applyStimulus(1'b1, 4'b0000, 16'h0, 16'h0);
        checkOutput("rr_reset", 4'b0000, 1'b0, 8'h00, 8'h00, 1'b0);
        for (int c = 0; c < 12; c++) begin
            applyStimulus(1'b0, 4'b1111, 16'h2121, 16'h5656);
            checkOutput($sformatf("rr_cycle[%0d]", c), e_ack, e_err, e_rd, e_wr, e_busy);
            if (req_ack != 0) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (req_ack[i]) begin
                        ack_idx.push_back(i);
                        ack_cyc.push_back(c);
                    end
                end
            end
        end
        order = '{0, 1, 2, 3, 0};
        if (ack_idx.size() < 5) begin
            checkValue("rr_ack_count", ack_idx.size(), 5);
        end else begin
            for (int k = 0; k < 5; k++) begin
                checkValue($sformatf("rr_order[%0d]", k), ack_idx[k], order[k]);
                if (k > 0) begin
                    checkValue($sformatf("rr_gap[%0d]", k), ack_cyc[k] - ack_cyc[k-1],
                               TURNAROUND ? 2 : 1);
                end
            end
            checkValue("rr_first_latency", ack_cyc[0], 0);
        end

        // Reset in the middle of a transfer: pointer returns to 0 and requester 0 is re-served.
        applyStimulus(1'b1, 4'b0000, 16'h0, 16'h0);
        applyStimulus(1'b0, 4'b0011, 16'h0041, 16'h0052);
        checkOutput("midrst_xfer", 4'b0001, 1'b0, 8'h02, 8'h04, 1'b1);
        applyStimulus(1'b1, 4'b0011, 16'h0041, 16'h0052);
        checkOutput("midrst_reset", 4'b0000, 1'b0, 8'h00, 8'h00, 1'b0);
        applyStimulus(1'b0, 4'b0011, 16'h0041, 16'h0052);
        checkOutput("midrst_reserve", 4'b0001, 1'b0, 8'h02, 8'h04, 1'b1);
        applyStimulus(1'b0, 4'b0010, 16'h0041, 16'h0052);
        checkOutput("midrst_next", e_ack, e_err, e_rd, e_wr, e_busy);
        applyStimulus(1'b0, 4'b0000, 16'h0, 16'h0);
        checkOutput("midrst_drain", e_ack, e_err, e_rd, e_wr, e_busy);

        // Random traffic with occasional resets and frequent src == dst.
        applyStimulus(1'b1, 4'b0000, 16'h0, 16'h0);
        for (int c = 0; c < 400; c++) begin
            rs   = 16'($urandom);
            rdst = ($urandom_range(0, 3) == 0) ? rs : 16'($urandom);
            applyStimulus($urandom_range(0, 49) == 0, 4'($urandom), rs, rdst);
            checkOutput($sformatf("rand[%0d]", c), e_ack, e_err, e_rd, e_wr, e_busy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule

// File: doc/bus_transfer_ctrl.md
BUS_TRANSFER_CTRL -- requirements
Module: bus_transfer_ctrl

Interface
REQ-001 SHALL have parameter N, default 16: data bus width, recorded for the bench; no logic depends on it.
REQ-002 SHALL have parameter NREG, default 16: number of registers on the shared bus.
REQ-003 SHALL have parameter NREQ, default 4: number of requesters.
REQ-004 SHALL have clk  input  1: clock; all state updates on rising edge.
REQ-005 SHALL have rst  input  1: reset, synchronous, active-high.
REQ-006 SHALL have req_valid  input  NREQ: per-requester transfer request.
REQ-007 SHALL have req_src  input  NREQ*4: per-requester source register index, requester i in bits [4i+3:4i].
REQ-008 SHALL have req_dst  input  NREQ*4: per-requester destination register index, same packing.
REQ-009 SHALL have req_ack  output  NREQ: one-cycle completion pulse per requester.
REQ-010 SHALL have req_err  output  1: high with req_ack when the acked request had an index >= NREG.
REQ-011 SHALL have rd_en  output  NREG: one-hot register bus-drive enables (register read inputs).
REQ-012 SHALL have wr_en  output  NREG: one-hot register bus-latch enables (register write inputs).
REQ-013 SHALL have busy  output  1: high in every state except IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, XFER, TURN; all outputs registered.
REQ-015 SHALL arbitrate in IDLE and TURN: if any req_valid, latch winner, src, dst, and go to XFER; else go to IDLE.
REQ-016 SHALL use round-robin: search starts at pointer p; after a grant to i, p = (i+1) mod NREQ.
REQ-017 SHALL, in XFER, assert rd_en[src], wr_en[dst] and req_ack[winner] for exactly one cycle, then go to TURN.
REQ-018 SHALL, in TURN, hold rd_en and wr_en all-zero (bus released, no driver).
REQ-019 SHALL keep latency from req_valid sampled in IDLE to req_ack at exactly 1 cycle.
REQ-020 SHALL never assert more than one bit of rd_en or of wr_en in any cycle.
REQ-021 SHALL, when src == dst, ack in XFER with rd_en and wr_en all-zero.
REQ-022 SHALL, when src >= NREG or dst >= NREG, ack in XFER with req_err=1 and no enables.
REQ-023 SHALL require requesters to hold req_valid, src and dst stable until ack; deassertion before grant withdraws the request.
REQ-024 SHALL ignore src/dst changes of the winner after latching.
REQ-025 SHALL let a requester whose valid stays high after ack be re-arbitrated as a new request.

Reset
REQ-026 SHALL, on rst, force state IDLE, p=0, and req_ack, req_err, rd_en, wr_en and busy to zero in the cycle after the edge.
REQ-027 SHALL drop an in-flight transfer on mid-operation rst with no ack; the requester keeps valid and is re-served.

Configuration
REQ-028 SHALL use macro BUS_TURNAROUND_EN.
REQ-029 SHALL, with BUS_TURNAROUND_EN defined, behave as above: at most one transfer per 2 cycles.
REQ-030 SHALL, without BUS_TURNAROUND_EN, omit TURN and arbitrate in XFER, allowing back-to-back XFER every cycle.

Structure
REQ-031 SHALL place the state encoding typedef and the index width constant (4) in package bus_pkg.
REQ-032 SHALL implement arbitration in sub-module rr_arbiter (inputs: request vector, pointer; outputs: one-hot grant, grant index, any).

Verification
REQ-033 SHALL cover: reset, then req_valid=0001 with src=3, dst=7 -> cycle 1: rd_en=0x0008, wr_en=0x0080, req_ack=0001; cycle 2: enables zero (TURN).
REQ-034 SHALL cover: req_valid=1111 held continuously after reset -> acks in order 0,1,2,3,0 with turnaround enabled, one ack every 2 cycles.
REQ-035 SHALL cover: src=5, dst=5 -> req_ack pulse, rd_en=wr_en=0, req_err=0.
REQ-036 SHALL cover: NREG=8, dst=9 -> req_ack with req_err=1, all enables zero.
REQ-037 SHALL cover: rst asserted during XFER -> next cycle all outputs zero, state IDLE, p=0, no ack; the request is served after rst drops.
REQ-038 SHALL cover: build without BUS_TURNAROUND_EN and req_valid=0011 -> acks on consecutive cycles (0 then 1); rd_en stays one-hot every cycle.
